// File: rtl/reg_scan_checker.sv
// reg_scan_checker
// Runs the processor for a programmable number of cycles, then takes over
// the regfile read-A port, scans every register and compares it with an
// expected-value ROM, reporting each mismatch and the totals.
// Optional build macro: REG_SCAN_STOP_ON_ERR_EN -- when defined, the first
// mismatch ends the scan and moves straight to DONE.
module reg_scan_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int CYCLE_WIDTH    = 16,
  parameter int DEFAULT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYCLE_WIDTH-1:0] num_cycles,
  input  logic                  cpu_rwe,
  input  logic [ADDR_WIDTH-1:0] cpu_rd,
  output logic                  run_en,
  output logic                  test_mode,
  output logic [ADDR_WIDTH-1:0] scan_addr,
  input  logic [DATA_WIDTH-1:0] scan_data,
  output logic [ADDR_WIDTH-1:0] exp_addr,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  mm_valid,
  output logic [ADDR_WIDTH-1:0] mm_reg,
  output logic [DATA_WIDTH-1:0] mm_exp,
  output logic [DATA_WIDTH-1:0] mm_act,
  output logic [CYCLE_WIDTH-1:0] write_count,
  output logic [ADDR_WIDTH:0]   error_count,
  output logic                  done,
  output logic                  pass
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [CYCLE_WIDTH-1:0] DEF_LIMIT = CYCLE_WIDTH'(DEFAULT_CYCLES);
  localparam logic [CYCLE_WIDTH-1:0] WC_MAX    = {CYCLE_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]    EC_MAX    = {(ADDR_WIDTH + 1){1'b1}};

`ifdef REG_SCAN_STOP_ON_ERR_EN
  localparam logic STOP_ON_ERR = 1'b1;
`else
  localparam logic STOP_ON_ERR = 1'b0;
`endif

  state_t state_reg, state_next;

  logic [CYCLE_WIDTH-1:0] cycle_reg;
  logic [CYCLE_WIDTH-1:0] limit_reg;
  logic [CYCLE_WIDTH-1:0] write_reg;
  logic [ADDR_WIDTH:0]    error_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;

  // Alignment stage: regfile data waits one cycle for the ROM's registered read.
  logic                  cap_valid_reg;
  logic [ADDR_WIDTH-1:0] cap_addr_reg;
  logic [DATA_WIDTH-1:0] cap_data_reg;

  logic                  mm_valid_reg;
  logic [ADDR_WIDTH-1:0] mm_reg_reg;
  logic [DATA_WIDTH-1:0] mm_exp_reg;
  logic [DATA_WIDTH-1:0] mm_act_reg;

  logic                  accept;
  logic                  abort;
  logic                  compare_en;
  logic                  mismatch;
  logic                  mm_hit;
  logic [DATA_WIDTH-1:0] diff_bits;

  // A start is only honoured when no run or scan is in flight.
  assign accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  // In stop-on-error builds, a reported mismatch ends the scan; any comparison
  // still in the pipeline at that point is discarded.
  assign abort = STOP_ON_ERR && mm_valid_reg &&
                 ((state_reg == S_SCAN) || (state_reg == S_DRAIN));

  // Per-bit difference between the captured register and the ROM word.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi = gi + 1) begin : g_diff
      assign diff_bits[gi] = cap_data_reg[gi] ^ exp_data[gi];
    end
  endgenerate

  assign mismatch   = |diff_bits;
  assign compare_en = cap_valid_reg && !abort;
  assign mm_hit     = compare_en && mismatch;

  // Next-state logic for the run / scan sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_RUN;
      end
      S_RUN: begin
        if (cycle_reg == (limit_reg - 1'b1)) state_next = S_SCAN;
      end
      S_SCAN: begin
        if (abort)                       state_next = S_DONE;
        else if (addr_reg == LAST_ADDR)  state_next = S_DRAIN;
      end
      S_DRAIN: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        if (accept) state_next = S_RUN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Run-length latch and cycle counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      limit_reg <= '0;
      cycle_reg <= '0;
    end else if (accept) begin
      limit_reg <= (num_cycles == '0) ? DEF_LIMIT : num_cycles;
      cycle_reg <= '0;
    end else if (state_reg == S_RUN) begin
      cycle_reg <= cycle_reg + 1'b1;
    end
  end

  // Saturating count of processor writes to non-zero registers during RUN.
  always_ff @(posedge clock) begin
    if (!reset) begin
      write_reg <= '0;
    end else if (accept) begin
      write_reg <= '0;
    end else if ((state_reg == S_RUN) && cpu_rwe && (cpu_rd != '0) &&
                 (write_reg != WC_MAX)) begin
      write_reg <= write_reg + 1'b1;
    end
  end

  // Scan address: walks 0..NUM_REGS-1 and then holds for debug reads in DONE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_reg <= '0;
    end else if (accept) begin
      addr_reg <= '0;
    end else if ((state_reg == S_SCAN) && !abort && (addr_reg != LAST_ADDR)) begin
      addr_reg <= addr_reg + 1'b1;
    end
  end

  // Capture regfile data together with its address for next-cycle compare.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cap_valid_reg <= 1'b0;
      cap_addr_reg  <= '0;
      cap_data_reg  <= '0;
    end else begin
      cap_valid_reg <= (state_reg == S_SCAN) && !abort;
      if (state_reg == S_SCAN) begin
        cap_addr_reg <= addr_reg;
        cap_data_reg <= scan_data;
      end
    end
  end

  // Mismatch report: pulse plus sticky details of the latest mismatch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mm_valid_reg <= 1'b0;
      mm_reg_reg   <= '0;
      mm_exp_reg   <= '0;
      mm_act_reg   <= '0;
    end else begin
      mm_valid_reg <= mm_hit;
      if (mm_hit) begin
        mm_reg_reg <= cap_addr_reg;
        mm_exp_reg <= exp_data;
        mm_act_reg <= cap_data_reg;
      end
    end
  end

  // Saturating mismatch total, cleared by each accepted start.
  always_ff @(posedge clock) begin
    if (!reset) begin
      error_reg <= '0;
    end else if (accept) begin
      error_reg <= '0;
    end else if (mm_hit && (error_reg != EC_MAX)) begin
      error_reg <= error_reg + 1'b1;
    end
  end

  assign run_en      = (state_reg == S_RUN);
  assign test_mode   = (state_reg == S_SCAN) || (state_reg == S_DRAIN) ||
                       (state_reg == S_DONE);
  assign scan_addr   = addr_reg;
  assign exp_addr    = addr_reg;
  assign mm_valid    = mm_valid_reg;
  assign mm_reg      = mm_reg_reg;
  assign mm_exp      = mm_exp_reg;
  assign mm_act      = mm_act_reg;
  assign write_count = write_reg;
  assign error_count = error_reg;
  assign done        = (state_reg == S_DONE);
  assign pass        = (state_reg == S_DONE) && (error_reg == '0);

endmodule

// File: tb/tb_reg_scan_checker.sv
// Testbench for reg_scan_checker: table-driven scenarios, hand-written corner
// sequences and randomized runs checked against a list-based reference model.
module tb_reg_scan_checker;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int DC = 255;

`ifdef REG_SCAN_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_cycles = '0;
  logic          cpu_rwe = 1'b0;
  logic [AW-1:0] cpu_rd = '0;
  logic          run_en;
  logic          test_mode;
  logic [AW-1:0] scan_addr;
  logic [DW-1:0] scan_data;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          mm_valid;
  logic [AW-1:0] mm_reg;
  logic [DW-1:0] mm_exp;
  logic [DW-1:0] mm_act;
  logic [CW-1:0] write_count;
  logic [AW:0]   error_count;
  logic          done;
  logic          pass;

  // Regfile and expected ROM models.
  logic [DW-1:0] rf [NR];
  logic [DW-1:0] em [NR];

  reg_scan_checker #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
    .CYCLE_WIDTH(CW), .DEFAULT_CYCLES(DC)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .cpu_rwe(cpu_rwe), .cpu_rd(cpu_rd), .run_en(run_en), .test_mode(test_mode),
    .scan_addr(scan_addr), .scan_data(scan_data), .exp_addr(exp_addr),
    .exp_data(exp_data), .mm_valid(mm_valid), .mm_reg(mm_reg), .mm_exp(mm_exp),
    .mm_act(mm_act), .write_count(write_count), .error_count(error_count),
    .done(done), .pass(pass)
  );

  always #5 clock = ~clock;

  // Combinational regfile read, one-cycle synchronous ROM read.
  assign scan_data = rf[scan_addr];
  always @(posedge clock) exp_data <= em[exp_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  typedef struct {
    int          r;
    logic [DW-1:0] e;
    logic [DW-1:0] a;
  } mm_t;

  typedef struct {
    int nc;
    int kind;
    bit sir;
    int exp_run;
    int exp_err;
  } vec_t;

  // kind 0: all match, 1: r3 5/6 and r31 0/all-ones, 2: random flips, 3: all differ
  task automatic load(input int kind);
    for (int i = 0; i < NR; i++) begin
      rf[i] = $urandom;
      em[i] = rf[i];
    end
    if (kind == 1) begin
      rf[3] = 32'd6;  em[3] = 32'd5;
      rf[31] = 32'hFFFF_FFFF; em[31] = 32'd0;
    end else if (kind == 2) begin
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 3) == 0) em[i] = rf[i] ^ (32'h1 << $urandom_range(0, 31));
    end else if (kind == 3) begin
      for (int i = 0; i < NR; i++) em[i] = ~rf[i];
    end
  endtask

  // One full start/run/scan transaction; the bench is at a negedge on entry
  // and exit. wmode 0: random writes, 1: rd list 0,4,4,0,9, 2: none.
  task automatic run_scenario(input int nc, input int wmode, input bit sir,
                              input string tag, output int run_cnt);
    mm_t exp_q[$];
    mm_t got_q[$];
    mm_t m;
    int  exp_run, wc_model, entry, done_idx, mm_idx;
    bit  timed_out;
    int  rd_list[5];
    rd_list = '{0, 4, 4, 0, 9};

    exp_run = (nc == 0) ? DC : nc;
    for (int i = 0; i < NR; i++) begin
      if (rf[i] != em[i] && !(STOP && exp_q.size() > 0)) begin
        m.r = i; m.e = em[i]; m.a = rf[i];
        exp_q.push_back(m);
      end
    end

    start = 1'b1;
    num_cycles = CW'(nc);
    @(negedge clock);
    start = 1'b0;
    num_cycles = CW'($urandom);
    check({tag, "_start_done"}, done, 0);
    check({tag, "_start_errcnt"}, error_count, 0);
    check({tag, "_start_wcnt"}, write_count, 0);

    run_cnt = 0; wc_model = 0; entry = -1; done_idx = -1; mm_idx = -1;
    timed_out = 1'b1;
    for (int c = 0; c < exp_run + 400; c++) begin
      if (mm_valid) begin
        m.r = int'(mm_reg); m.e = mm_exp; m.a = mm_act;
        got_q.push_back(m);
        if (mm_idx < 0) mm_idx = c;
      end
      if (test_mode && entry < 0) entry = c;
      if (done) begin
        done_idx = c;
        timed_out = 1'b0;
        break;
      end
      if (run_en) begin
        run_cnt++;
        if (wmode == 0) begin
          cpu_rwe = 1'($urandom_range(0, 1));
          cpu_rd  = AW'($urandom_range(0, NR - 1));
        end else if (wmode == 1 && run_cnt <= 5) begin
          cpu_rwe = 1'b1;
          cpu_rd  = AW'(rd_list[run_cnt - 1]);
        end else begin
          cpu_rwe = 1'b0;
          cpu_rd  = AW'($urandom_range(0, NR - 1));
        end
        if (cpu_rwe && cpu_rd != 0) wc_model++;
        start = (sir && run_cnt == 3);
        num_cycles = CW'($urandom_range(1, 3));
      end else begin
        cpu_rwe = 1'b0;
        start = 1'b0;
      end
      @(negedge clock);
    end
    cpu_rwe = 1'b0;
    start = 1'b0;

    check({tag, "_timeout"}, timed_out, 0);
    if (timed_out) return;

    check({tag, "_run_cycles"}, run_cnt, exp_run);
    if (STOP && exp_q.size() > 0)
      check({tag, "_done_after_mm"}, done_idx - mm_idx, (exp_q[0].r == NR - 1) ? 0 : 1);
    else
      check({tag, "_scan_latency"}, done_idx - entry, NR + 1);
    check({tag, "_write_count"}, write_count, wc_model);
    check({tag, "_error_count"}, error_count, exp_q.size());
    check({tag, "_pass"}, pass, exp_q.size() == 0);
    check({tag, "_test_mode_done"}, test_mode, 1);
    check({tag, "_run_en_done"}, run_en, 0);
    check({tag, "_mm_pulses"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_mm_reg"}, got_q[i].r, exp_q[i].r);
      check({tag, "_mm_exp"}, got_q[i].e, exp_q[i].e);
      check({tag, "_mm_act"}, got_q[i].a, exp_q[i].a);
    end
    $display("scenario %s: nc=%0d run=%0d writes=%0d mismatches=%0d pass=%0d",
             tag, nc, run_cnt, write_count, error_count, pass);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_run_en"}, run_en, 0);
    check({tag, "_test_mode"}, test_mode, 0);
    check({tag, "_scan_addr"}, scan_addr, 0);
    check({tag, "_mm_valid"}, mm_valid, 0);
    check({tag, "_mm_reg"}, mm_reg, 0);
    check({tag, "_mm_exp"}, mm_exp, 0);
    check({tag, "_mm_act"}, mm_act, 0);
    check({tag, "_write_count"}, write_count, 0);
    check({tag, "_error_count"}, error_count, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
  endtask

  initial begin
    vec_t vecs[5];
    int   rc;
    bit   found;

    vecs[0] = '{nc: 10, kind: 0, sir: 1'b0, exp_run: 10,  exp_err: 0};
    vecs[1] = '{nc: 0,  kind: 0, sir: 1'b0, exp_run: 255, exp_err: 0};
    vecs[2] = '{nc: 20, kind: 1, sir: 1'b1, exp_run: 20,  exp_err: 2};
    vecs[3] = '{nc: 1,  kind: 1, sir: 1'b0, exp_run: 1,   exp_err: 2};
    vecs[4] = '{nc: 5,  kind: 3, sir: 1'b1, exp_run: 5,   exp_err: 32};

    // Power-up reset, with start held high to show reset wins.
    load(0);
    reset = 1'b0;
    start = 1'b1;
    num_cycles = 16'd4;
    repeat (3) @(negedge clock);
    check_all_zero("reset_init");
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("idle_run_en", run_en, 0);
    $display("transaction reset_init done=%0d run_en=%0d", done, run_en);

    // Reset in the middle of a scan, after a mismatch at r5 was reported.
    load(0);
    em[5] = rf[5] ^ 32'h10;
    start = 1'b1;
    num_cycles = 16'd3;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (test_mode && scan_addr == 5'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("midscan_reach_addr7", found, 1);
    check("midscan_errcnt_before", error_count, 1);
    check("midscan_mmreg_before", mm_reg, 5);
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset_midscan");
    reset = 1'b1;
    @(negedge clock);
    $display("transaction reset_midscan scan_addr=%0d done=%0d", scan_addr, done);

    // Table-driven scenarios, run back to back so each restarts from DONE.
    for (int v = 0; v < 5; v++) begin
      load(vecs[v].kind);
      run_scenario(vecs[v].nc, 0, vecs[v].sir, $sformatf("vec%0d", v), rc);
      check($sformatf("vec%0d_table_run", v), rc, vecs[v].exp_run);
      check($sformatf("vec%0d_table_err", v), error_count,
            (STOP && vecs[v].exp_err > 1) ? 1 : vecs[v].exp_err);
    end

    // Monitored write sequence rd = 0,4,4,0,9.
    load(0);
    run_scenario(8, 1, 1'b0, "writes", rc);
    check("writes_fixed_count", write_count, 3);

    // Randomized runs against the reference model.
    for (int k = 0; k < 8; k++) begin
      load(2);
      run_scenario($urandom_range(0, 40), 0, 1'($urandom_range(0, 1)),
                   $sformatf("rand%0d", k), rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
